// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/clear/lap FSM, internal tick prescaler,
// MM:SS.t BCD time counter with wrap, lap snapshot and registered display digits.
module stopwatch_ctrl #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 10
) (
  input  logic       clk_100MHz,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic       tick,
  output logic       running,
  output logic       lap_hold,
  output logic       wrap,
  output logic [3:0] d_tenths,
  output logic [3:0] d_sec_lo,
  output logic [3:0] d_sec_hi,
  output logic [3:0] d_min_lo,
  output logic [3:0] d_min_hi
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pcnt;
  logic [3:0]    t_ten, t_slo, t_shi, t_mlo, t_mhi;
  logic [19:0]   live, snap;
  logic          clr_go, ss_go, lap_go, tick_now, at_max;

  assign live = {t_mhi, t_mlo, t_shi, t_slo, t_ten};

  // Pulse arbitration: only the highest-priority pulse legal in this state acts.
  assign clr_go   = clear & (state != S_RUN);
  assign ss_go    = start_stop & ~clr_go;
  assign lap_go   = lap & ~clr_go & ~ss_go & (state != S_IDLE);
  assign tick_now = (state == S_RUN) && (pcnt == PMAX);
  assign at_max   = (t_ten == 4'd9) && (t_slo == 4'd9) && (t_shi == 4'd5) &&
                    (t_mlo == 4'd9) && (t_mhi == 4'd5);

  // Next-state decode for the run/pause/idle FSM.
  always_comb begin
    state_nxt = state;
    if (clr_go)     state_nxt = S_IDLE;
    else if (ss_go) state_nxt = (state == S_RUN) ? S_PAUSE : S_RUN;
  end

  // FSM state, running flag and lap freeze; running mirrors the state register.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      running  <= 1'b0;
      lap_hold <= 1'b0;
      snap     <= '0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == S_RUN);
      if (clr_go) begin
        lap_hold <= 1'b0;
        snap     <= '0;
      end else if (lap_go) begin
        lap_hold <= ~lap_hold;
        if (!lap_hold) snap <= live;
      end
    end
  end

  // Prescaler and BCD time cascade; prescaler holds in PAUSE to keep the partial interval.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      pcnt  <= '0;
      t_ten <= '0; t_slo <= '0; t_shi <= '0; t_mlo <= '0; t_mhi <= '0;
    end else if (clr_go) begin
      pcnt  <= '0;
      t_ten <= '0; t_slo <= '0; t_shi <= '0; t_mlo <= '0; t_mhi <= '0;
    end else if (state == S_IDLE) begin
      pcnt <= '0;
    end else if (state == S_RUN) begin
      if (!tick_now) begin
        pcnt <= pcnt + PW'(1);
      end else begin
        pcnt <= '0;
        if (t_ten != 4'd9) t_ten <= t_ten + 4'd1;
        else begin
          t_ten <= '0;
          if (t_slo != 4'd9) t_slo <= t_slo + 4'd1;
          else begin
            t_slo <= '0;
            if (t_shi != 4'd5) t_shi <= t_shi + 4'd1;
            else begin
              t_shi <= '0;
              if (t_mlo != 4'd9) t_mlo <= t_mlo + 4'd1;
              else begin
                t_mlo <= '0;
                if (t_mhi != 4'd5) t_mhi <= t_mhi + 4'd1;
                else               t_mhi <= '0;
              end
            end
          end
        end
      end
    end
  end

  // Registered strobes and display digits (display lags the live time by one cycle).
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      tick <= 1'b0;
      wrap <= 1'b0;
      {d_min_hi, d_min_lo, d_sec_hi, d_sec_lo, d_tenths} <= '0;
    end else begin
      tick <= tick_now;
      wrap <= tick_now & at_max;
      {d_min_hi, d_min_lo, d_sec_hi, d_sec_lo, d_tenths} <= lap_hold ? snap : live;
    end
  end

endmodule
